// File: rtl/dm_resp.sv
// Single-port word memory behind a fixed-latency Req/Ack handshake.
// Each accepted request completes with a one-cycle Ack after LATENCY cycles.
module dm_resp #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        MemWr,
    input  logic [31:0] Addr,
    input  logic [31:0] WD,
    input  logic [3:0]  BE,
    output logic        Ack,
    output logic [31:0] RD,
    output logic        Err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q;
    logic [31:0] addr_q, wd_q;
    logic [3:0]  be_q;
    logic [31:0] rd_q;
    logic        err_q;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic          accept;
    logic          enter_resp;
    logic [31:0]   op_addr;
    logic          op_err;
    logic [AW-1:0] op_idx;
    logic [AW-1:0] wr_idx;

    assign accept = (state_q == IDLE) && Req;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (Req) begin
                    state_d = (LATENCY == 1) ? RESP : BUSY;
                    cnt_d   = CNT_INIT;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign enter_resp = (state_d == RESP) && (state_q != RESP);

    // With LATENCY=1 the response is formed on the accept edge, so use the live inputs.
    assign op_addr = (state_q == IDLE) ? Addr : addr_q;
    assign op_err  = (op_addr[1:0] != 2'b00) || ({2'b00, op_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign op_idx  = op_addr[AW+1:2];
    assign wr_idx  = addr_q[AW+1:2];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wd_q    <= '0;
            be_q    <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wr_q   <= MemWr;
                addr_q <= Addr;
                wd_q   <= WD;
                be_q   <= BE;
            end
            if (enter_resp) begin
                err_q <= op_err;
                rd_q  <= op_err ? 32'd0 : mem_q[op_idx];
            end
        end
    end

    // The write commits on the edge that ends RESP, so RD carries the pre-write word.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
                mem_q[i] <= '0;
            end
        end else if ((state_q == RESP) && wr_q && !err_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem_q[wr_idx][8*b +: 8] <= wd_q[8*b +: 8];
                end
            end
        end
    end

    assign Ack = (state_q == RESP);
    assign RD  = rd_q;
    assign Err = err_q;

endmodule

// File: tb/tb_dm_resp.sv
// Directed bench for dm_resp: three instances (LATENCY 1, 2, 4) share stimulus,
// each scenario resets first and checks only the selected instance.
module tb_dm_resp;

    logic        Clk = 1'b0;
    logic        Reset, Req, MemWr;
    logic [31:0] Addr, WD;
    logic [3:0]  BE;

    logic        ack1, ack2, ack4;
    logic [31:0] rd1, rd2, rd4;
    logic        err1, err2, err4;

    int          sel;
    logic        ack_s;
    logic [31:0] rd_s;
    logic        err_s;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    always #5 Clk = ~Clk;

    dm_resp #(.DEPTH_WORDS(16), .LATENCY(1)) u_l1 (
        .Clk(Clk), .Reset(Reset), .Req(Req), .MemWr(MemWr), .Addr(Addr), .WD(WD), .BE(BE),
        .Ack(ack1), .RD(rd1), .Err(err1)
    );
    dm_resp #(.DEPTH_WORDS(1024), .LATENCY(2)) u_l2 (
        .Clk(Clk), .Reset(Reset), .Req(Req), .MemWr(MemWr), .Addr(Addr), .WD(WD), .BE(BE),
        .Ack(ack2), .RD(rd2), .Err(err2)
    );
    dm_resp #(.DEPTH_WORDS(16), .LATENCY(4)) u_l4 (
        .Clk(Clk), .Reset(Reset), .Req(Req), .MemWr(MemWr), .Addr(Addr), .WD(WD), .BE(BE),
        .Ack(ack4), .RD(rd4), .Err(err4)
    );

    always_comb begin
        ack_s = ack2;
        rd_s  = rd2;
        err_s = err2;
        case (sel)
            1: begin ack_s = ack1; rd_s = rd1; err_s = err1; end
            4: begin ack_s = ack4; rd_s = rd4; err_s = err4; end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; leaves the bench at a negedge with Reset low.
    task automatic do_reset();
        Reset = 1'b1;
        Req   = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    // One request; inputs are scrambled while waiting to prove they were captured.
    task automatic xact(input string tag, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be, input int lat,
                        input logic [31:0] exp_rd, input logic exp_err);
        int   k;
        logic seen;
        MemWr = wr;
        Addr  = a;
        WD    = d;
        BE    = be;
        Req   = 1'b1;
        @(posedge Clk);
        seen = 1'b0;
        k    = 0;
        while (!seen && k < 20) begin
            @(negedge Clk);
            k++;
            if (ack_s) begin
                seen = 1'b1;
            end else begin
                Addr  = Addr ^ 32'h4;
                WD    = ~WD;
                BE    = ~BE;
                MemWr = ~MemWr;
            end
        end
        Req = 1'b0;
        check({tag, "_ack_cycle"}, 32'(k), 32'(lat));
        check({tag, "_rd"}, rd_s, exp_rd);
        check({tag, "_err"}, 32'(err_s), 32'(exp_err));
        @(negedge Clk);
        check({tag, "_ack_single"}, 32'(ack_s), 32'd0);
        check({tag, "_rd_hold"}, rd_s, exp_rd);
    endtask

    initial begin
        Reset = 1'b1;
        Req   = 1'b0;
        MemWr = 1'b0;
        Addr  = '0;
        WD    = '0;
        BE    = '0;
        sel   = 2;
        @(negedge Clk);
        do_reset();
        check("rst_ack", 32'(ack_s), 32'd0);
        check("rst_rd", rd_s, 32'd0);
        check("rst_err", 32'(err_s), 32'd0);

        // LATENCY=2: full write then readback
        @(negedge Clk);
        xact("wr10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 2, 32'h0, 1'b0);
        xact("rd10", 1'b0, 32'h10, 32'h0, 4'h0, 2, 32'hDEADBEEF, 1'b0);

        // Partial write returns the pre-write word, then merged readback
        xact("wr20", 1'b1, 32'h20, 32'hAABBCCDD, 4'hF, 2, 32'h0, 1'b0);
        xact("wr20p", 1'b1, 32'h20, 32'h11223344, 4'b0101, 2, 32'hAABBCCDD, 1'b0);
        xact("rd20", 1'b0, 32'h20, 32'h0, 4'hF, 2, 32'hAA22CC44, 1'b0);

        // Error cases: misaligned read, out-of-range write, misaligned write
        xact("rd13", 1'b0, 32'h13, 32'h0, 4'hF, 2, 32'h0, 1'b1);
        xact("wr_oor", 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 2, 32'h0, 1'b1);
        xact("wr11", 1'b1, 32'h11, 32'h12345678, 4'hF, 2, 32'h0, 1'b1);
        xact("rd0", 1'b0, 32'h0, 32'h0, 4'h0, 2, 32'h0, 1'b0);
        xact("rd10b", 1'b0, 32'h10, 32'h0, 4'h0, 2, 32'hDEADBEEF, 1'b0);

        // Zero byte enables: legal no-op
        xact("wr10_be0", 1'b1, 32'h10, 32'h0, 4'h0, 2, 32'hDEADBEEF, 1'b0);
        xact("rd10c", 1'b0, 32'h10, 32'h0, 4'h0, 2, 32'hDEADBEEF, 1'b0);

        // Reset while BUSY aborts the write and clears memory
        MemWr = 1'b1;
        Addr  = 32'h30;
        WD    = 32'h12345678;
        BE    = 4'hF;
        Req   = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        Req   = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        check("busy_rst_ack", 32'(ack_s), 32'd0);
        check("busy_rst_rd", rd_s, 32'd0);
        check("busy_rst_err", 32'(err_s), 32'd0);
        xact("rd30", 1'b0, 32'h30, 32'h0, 4'h0, 2, 32'h0, 1'b0);
        xact("rd10_clr", 1'b0, 32'h10, 32'h0, 4'h0, 2, 32'h0, 1'b0);

        // Reset during RESP: no write committed, no further Ack
        MemWr = 1'b1;
        Addr  = 32'h34;
        WD    = 32'h55AA55AA;
        BE    = 4'hF;
        Req   = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        @(negedge Clk);
        check("resp_ack_before_rst", 32'(ack_s), 32'd1);
        Reset = 1'b1;
        Req   = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        check("resp_rst_ack", 32'(ack_s), 32'd0);
        xact("rd34", 1'b0, 32'h34, 32'h0, 4'h0, 2, 32'h0, 1'b0);

        // Reset has priority over a simultaneous Req
        Reset = 1'b1;
        Req   = 1'b1;
        MemWr = 1'b1;
        Addr  = 32'h40;
        WD    = 32'hFFFFFFFF;
        BE    = 4'hF;
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        Req   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rst_prio_no_ack", 32'(ack_s), 32'd0);
            @(negedge Clk);
        end
        xact("rd40", 1'b0, 32'h40, 32'h0, 4'h0, 2, 32'h0, 1'b0);

        // LATENCY=1: Req held high gives Ack every other cycle
        sel = 1;
        do_reset();
        MemWr = 1'b0;
        Addr  = 32'h0;
        BE    = 4'h0;
        Req   = 1'b1;
        @(posedge Clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge Clk);
            check($sformatf("l1_stream_c%0d", k), 32'(ack_s), 32'(k % 2));
        end
        Req = 1'b0;
        @(negedge Clk);
        xact("l1_wr4", 1'b1, 32'h4, 32'h0BADF00D, 4'hF, 1, 32'h0, 1'b0);
        xact("l1_rd4", 1'b0, 32'h4, 32'h0, 4'h0, 1, 32'h0BADF00D, 1'b0);

        // LATENCY=4: inputs changed while BUSY must be ignored
        sel = 4;
        do_reset();
        xact("l4_wr8", 1'b1, 32'h8, 32'hCAFEF00D, 4'hF, 4, 32'h0, 1'b0);
        xact("l4_rd8", 1'b0, 32'h8, 32'h0, 4'h0, 4, 32'hCAFEF00D, 1'b0);
        xact("l4_rdc", 1'b0, 32'hC, 32'h0, 4'h0, 4, 32'h0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dm_resp.md
DM_RESP -- requirements
Module: dm_resp

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words stored (4 KB).
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request acceptance to Ack; legal range 1..15.
REQ-003 SHALL have port Clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port Reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port Req, input, 1, initiator request; held high until Ack is observed.
REQ-006 SHALL have port MemWr, input, 1, 1 = write, 0 = read.
REQ-007 SHALL have port Addr, input, 32, byte address.
REQ-008 SHALL have port WD, input, 32, write data.
REQ-009 SHALL have port BE, input, 4, byte enables; BE[i] selects WD[8i+7:8i].
REQ-010 SHALL have port Ack, output, 1, single-cycle completion pulse.
REQ-011 SHALL have port RD, output, 32, read data, valid in the Ack cycle.
REQ-012 SHALL have port Err, output, 1, error flag, valid in the Ack cycle.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY and RESP.
REQ-014 SHALL accept a request only when state is IDLE and Req=1; MemWr, Addr, WD and BE are captured on that edge, and later input changes are ignored until the next IDLE.
REQ-015 SHALL transition IDLE->RESP on accept if LATENCY=1; otherwise IDLE->BUSY and load a down-counter with LATENCY-2.
REQ-016 SHALL remain in BUSY while counter != 0, decrement each cycle, and go BUSY->RESP when counter = 0.
REQ-017 SHALL go RESP->IDLE unconditionally; Ack=1 only in RESP, so Req accepted in cycle c gives Ack in cycle c+LATENCY.
REQ-018 SHALL ignore Req during the RESP cycle; back-to-back requests therefore have a minimum spacing of LATENCY+1 cycles.
REQ-019 SHALL set Err=1 in RESP if captured Addr[1:0] != 0 or word index Addr[31:2] >= DEPTH_WORDS; the Err flag is otherwise 0.
REQ-020 SHALL, on an error, perform no memory write and return RD = 0.
REQ-021 SHALL, for a non-error write, update only enabled bytes of word Addr[31:2] at the edge ending the RESP cycle, and return RD = pre-write word contents.
REQ-022 SHALL, for a non-error read, drive RD = stored word in RESP; BE is ignored for reads.
REQ-023 SHALL hold RD and Err at their last RESP values outside RESP; they are 0 after reset.
REQ-024 SHALL treat a write with BE = 4'b0000 as a legal no-op with Ack and Err=0.
REQ-025 SHALL, when a write is followed by a read of the same address, return the newly written data.

Reset
REQ-026 SHALL, when Reset=1 at a rising edge, force state IDLE, counter 0, Ack=0, RD=0 and Err=0, and clear all memory words to 0.
REQ-027 SHALL abort any in-flight request on Reset, including one in RESP, with no write committed and no Ack in the following cycle.
REQ-028 SHALL give Reset priority over a simultaneous Req; no request is accepted on a reset edge.

Verification
REQ-029 SHALL pass this scenario: LATENCY=2; write Addr=0x10, WD=0xDEADBEEF, BE=4'hF accepted at cycle 5 -> Ack=1 at cycle 7 only, Err=0; a following read of 0x10 -> RD=0xDEADBEEF.
REQ-030 SHALL pass this scenario: partial write BE=4'b0101, WD=0x11223344 to a word holding 0xAABBCCDD -> subsequent read RD=0xAA22CC44.
REQ-031 SHALL pass this scenario: read Addr=0x13 (misaligned), then write Addr=4*DEPTH_WORDS -> both Ack with Err=1, RD=0, and memory unchanged.
REQ-032 SHALL pass this scenario: Req held high continuously for 10 cycles with LATENCY=1 -> Ack on cycles 1,3,5,7,9 after first accept.
REQ-033 SHALL pass this scenario: write accepted, Reset asserted in BUSY -> no Ack, Ack/RD/Err=0, and a read of that address after reset returns 0.
REQ-034 SHALL pass this scenario: LATENCY=4; Addr/WD changed while BUSY -> captured values used, Ack exactly 4 cycles after accept.
